// File: rtl/codec_pkg.sv
// Shared types and width helpers for the 2-D even-parity product code link.
package codec_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,
    ST_CORR   = 2'b01,
    ST_PAR    = 2'b10,
    ST_UNCORR = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DECODE = 2'b01,
    S_REPORT = 2'b10
  } state_e;

  function automatic int cw_width(input int rows, input int cols);
    return rows * cols + rows + cols;
  endfunction

  // Index width that never collapses to zero for a single row or column.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parity_syndrome.sv
// Combinational even-parity generator for a ROWS x COLS bit matrix.
// Cell (r,c) lives at data bit r*COLS+c.
module parity_syndrome #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS-1:0] data,
  output logic [ROWS-1:0]      row_par,
  output logic [COLS-1:0]      col_par
);

  always_comb begin
    row_par = '0;
    col_par = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        row_par[r] = row_par[r] ^ data[r*COLS+c];
        col_par[c] = col_par[c] ^ data[r*COLS+c];
      end
    end
  end

endmodule

// File: rtl/product_code_link.sv
// Product-code link: encode, inject channel errors, decode/correct, classify,
// and stream every candidate error position on its own valid/ready port.
module product_code_link
  import codec_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int MAX_POS = 16,
  parameter int DATA_W  = ROWS * COLS,
  parameter int CW_W    = cw_width(ROWS, COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [CW_W-1:0]               chan_err_mask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [1:0]                    out_status,
  output logic [cnt_width(MAX_POS)-1:0] out_err_count,
  output logic                          pos_valid,
  input  logic                          pos_ready,
  output logic [idx_width(ROWS)-1:0]    pos_row,
  output logic [idx_width(COLS)-1:0]    pos_col,
  output logic                          pos_last
);

  localparam int ROW_W = idx_width(ROWS);
  localparam int COL_W = idx_width(COLS);
  localparam int CNT_W = cnt_width(MAX_POS);
  localparam int RC_W  = cnt_width(ROWS);
  localparam int CC_W  = cnt_width(COLS);

  state_e              state_q, state_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic [DATA_W-1:0]   data_q, data_d;
  status_e             status_q, status_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ROWS-1:0]     row_syn_q, row_syn_d;
  logic [COLS-1:0]     col_syn_q, col_syn_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic [COL_W-1:0]    col_idx_q, col_idx_d;
  logic [CNT_W-1:0]    emitted_q, emitted_d;
  logic                live_q, live_d;
  logic                out_done_q, out_done_d;
  logic                walk_done_q, walk_done_d;

  logic [ROWS-1:0]     enc_row_par, chk_row_par, row_syn;
  logic [COLS-1:0]     enc_col_par, chk_col_par, col_syn;
  logic [RC_W-1:0]     r_cnt;
  logic [CC_W-1:0]     c_cnt;
  int                  prod;
  logic [DATA_W-1:0]   flip;
  logic [DATA_W-1:0]   cls_data;
  status_e             cls_status;
  logic [CNT_W-1:0]    cls_count;

  logic in_fire, out_fire;
  logic cell_hit, last_cell, emit_last, advance;

  parity_syndrome #(.ROWS(ROWS), .COLS(COLS)) u_enc (
    .data    (in_data),
    .row_par (enc_row_par),
    .col_par (enc_col_par)
  );

  parity_syndrome #(.ROWS(ROWS), .COLS(COLS)) u_chk (
    .data    (cw_q[DATA_W-1:0]),
    .row_par (chk_row_par),
    .col_par (chk_col_par)
  );

  assign row_syn = chk_row_par ^ cw_q[DATA_W +: ROWS];
  assign col_syn = chk_col_par ^ cw_q[DATA_W+ROWS +: COLS];

  // The outer product of the syndromes marks every candidate cell; with a
  // single row and column mismatch it is exactly the bit to correct.
  always_comb begin
    r_cnt      = '0;
    c_cnt      = '0;
    flip       = '0;
    prod       = 0;
    cls_status = ST_UNCORR;
    cls_count  = '0;
    for (int r = 0; r < ROWS; r++) r_cnt = r_cnt + RC_W'(row_syn[r]);
    for (int c = 0; c < COLS; c++) c_cnt = c_cnt + CC_W'(col_syn[c]);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        flip[r*COLS+c] = row_syn[r] & col_syn[c];
      end
    end
    prod = int'(r_cnt) * int'(c_cnt);
    if (r_cnt == '0 && c_cnt == '0) begin
      cls_status = ST_CLEAN;
    end else if (r_cnt == RC_W'(1) && c_cnt == CC_W'(1)) begin
      cls_status = ST_CORR;
    end else if ((r_cnt == RC_W'(1) && c_cnt == '0) ||
                 (r_cnt == '0 && c_cnt == CC_W'(1))) begin
      cls_status = ST_PAR;
    end
    if (cls_status == ST_CLEAN || cls_status == ST_PAR) begin
      cls_count = '0;
    end else if (prod > MAX_POS) begin
      cls_count = CNT_W'(MAX_POS);
    end else begin
      cls_count = CNT_W'(prod);
    end
    cls_data = cw_q[DATA_W-1:0] ^ ((cls_status == ST_CORR) ? flip : '0);
  end

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign cell_hit  = row_syn_q[row_idx_q] & col_syn_q[col_idx_q];
  assign last_cell = (row_idx_q == ROW_W'(ROWS-1)) && (col_idx_q == COL_W'(COLS-1));
  assign emit_last = (emitted_q + CNT_W'(1)) == count_q;

  always_comb begin
    cw_d        = cw_q;
    data_d      = data_q;
    status_d    = status_q;
    count_d     = count_q;
    row_syn_d   = row_syn_q;
    col_syn_d   = col_syn_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    emitted_d   = emitted_q;
    out_done_d  = out_done_q;
    walk_done_d = walk_done_q;
    live_d      = (state_q == S_REPORT);
    advance     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_fire) cw_d = {enc_col_par, enc_row_par, in_data} ^ chan_err_mask;
      end
      S_DECODE: begin
        data_d      = cls_data;
        status_d    = cls_status;
        count_d     = cls_count;
        row_syn_d   = row_syn;
        col_syn_d   = col_syn;
        row_idx_d   = '0;
        col_idx_d   = '0;
        emitted_d   = '0;
        out_done_d  = 1'b0;
        walk_done_d = (cls_count == '0);
      end
      S_REPORT: begin
        if (out_fire) out_done_d = 1'b1;
        // Non-candidate cells are skipped at one per cycle; a candidate stalls until taken.
        if (live_q && !walk_done_q) begin
          if (!cell_hit) begin
            advance = 1'b1;
          end else if (pos_ready) begin
            emitted_d = emitted_q + CNT_W'(1);
            if (emit_last) walk_done_d = 1'b1;
            else           advance     = 1'b1;
          end
        end
        if (advance) begin
          if (last_cell) begin
            walk_done_d = 1'b1;
          end else if (col_idx_q == COL_W'(COLS-1)) begin
            col_idx_d = '0;
            row_idx_d = row_idx_q + ROW_W'(1);
          end else begin
            col_idx_d = col_idx_q + COL_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_fire) state_d = S_DECODE;
      S_DECODE: state_d = S_REPORT;
      S_REPORT: if (out_done_d && walk_done_d) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cw_q        <= '0;
      data_q      <= '0;
      status_q    <= ST_CLEAN;
      count_q     <= '0;
      row_syn_q   <= '0;
      col_syn_q   <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      emitted_q   <= '0;
      live_q      <= 1'b0;
      out_done_q  <= 1'b0;
      walk_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      data_q      <= data_d;
      status_q    <= status_d;
      count_q     <= count_d;
      row_syn_q   <= row_syn_d;
      col_syn_q   <= col_syn_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      emitted_q   <= emitted_d;
      live_q      <= live_d;
      out_done_q  <= out_done_d;
      walk_done_q <= walk_done_d;
    end
  end

  // live_q holds results back for the first REPORT cycle, giving two-cycle latency.
  always_comb begin
    in_ready      = rst && (state_q == S_IDLE);
    out_valid     = (state_q == S_REPORT) && live_q && !out_done_q;
    pos_valid     = (state_q == S_REPORT) && live_q && !walk_done_q && cell_hit;
    pos_last      = pos_valid && emit_last;
    out_data      = data_q;
    out_status    = status_q;
    out_err_count = count_q;
    pos_row       = row_idx_q;
    pos_col       = col_idx_q;
  end

endmodule

// File: tb/tb_product_code_link.sv
// Directed, table-driven bench for product_code_link (8x8, MAX_POS=16).
module tb_product_code_link;

  localparam int ROWS = 8, COLS = 8, MAX_POS = 16;
  localparam int DATA_W = 64, CW_W = 80, CNT_W = 5, ROW_W = 3, COL_W = 3;
  localparam int NVEC = 10;
  localparam logic [CW_W-1:0] ONE = 1;

  typedef struct packed {
    logic [DATA_W-1:0]                         data;
    logic [CW_W-1:0]                           mask;
    logic [DATA_W-1:0]                         exp_data;
    logic [1:0]                                exp_status;
    logic [CNT_W-1:0]                          exp_count;
    logic [MAX_POS-1:0][ROW_W+COL_W-1:0]       exp_pos;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [CW_W-1:0]     chan_err_mask;
  logic                out_valid, out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_status;
  logic [CNT_W-1:0]    out_err_count;
  logic                pos_valid, pos_ready, pos_last;
  logic [ROW_W-1:0]    pos_row;
  logic [COL_W-1:0]    pos_col;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NVEC];

  int   w, lat, n;
  bit   out_done, stall, out_hs;
  logic [5:0] stall_pos;

  always #5 clk = ~clk;

  product_code_link #(.ROWS(ROWS), .COLS(COLS), .MAX_POS(MAX_POS)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .chan_err_mask (chan_err_mask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_status    (out_status),
    .out_err_count (out_err_count),
    .pos_valid     (pos_valid),
    .pos_ready     (pos_ready),
    .pos_row       (pos_row),
    .pos_col       (pos_col),
    .pos_last      (pos_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic [63:0] d, input logic [79:0] m, input logic [63:0] ed,
                                 input logic [1:0] st, input logic [4:0] cnt);
    vec_t v;
    v.data = d; v.mask = m; v.exp_data = ed; v.exp_status = st; v.exp_count = cnt;
    v.exp_pos = '0;
    return v;
  endfunction

  // Waits (bounded) for in_ready, presents the word and returns after the accept edge.
  task automatic applyStimulus(input vec_t v, output int waited);
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkValue("in_ready before accept", in_ready, 1);
    in_valid      = 1'b1;
    in_data       = v.data;
    chan_err_mask = v.mask;
    tick();
    in_valid      = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int id);
    int l, cnt;
    out_ready = 1'b0;
    pos_ready = 1'b1;
    l = 0;
    while (!out_valid && l < 10) begin
      tick();
      l++;
    end
    checkValue($sformatf("v%0d latency", id), l, 2);
    checkValue($sformatf("v%0d out_data", id), out_data, v.exp_data);
    checkValue($sformatf("v%0d out_status", id), out_status, v.exp_status);
    checkValue($sformatf("v%0d out_err_count", id), out_err_count, v.exp_count);
    checkValue($sformatf("v%0d in_ready busy", id), in_ready, 0);
    cnt = 0;
    for (int k = 0; k < 70; k++) begin
      if (pos_valid) begin
        if (cnt < int'(v.exp_count)) begin
          checkValue($sformatf("v%0d pos%0d", id, cnt), {pos_row, pos_col}, v.exp_pos[cnt]);
          checkValue($sformatf("v%0d pos%0d last", id, cnt), pos_last, (cnt + 1 == int'(v.exp_count)));
        end
        cnt++;
      end
      tick();
    end
    checkValue($sformatf("v%0d positions", id), cnt, v.exp_count);
    checkValue($sformatf("v%0d out_valid held", id), out_valid, 1);
    checkValue($sformatf("v%0d out_data held", id), out_data, v.exp_data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkValue($sformatf("v%0d out_valid after hs", id), out_valid, 0);
    checkValue($sformatf("v%0d in_ready after hs", id), in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; chan_err_mask = '0;
    out_ready = 1'b0; pos_ready = 1'b0;

    vecs[0] = mkVec(64'h0123456789ABCDEF, '0, 64'h0123456789ABCDEF, 2'b00, 5'd0);
    vecs[1] = mkVec(64'h0123456789ABCDEF, ONE << 29, 64'h0123456789ABCDEF, 2'b01, 5'd1);
    vecs[1].exp_pos[0] = {3'd3, 3'd5};
    vecs[2] = mkVec(64'h0123456789ABCDEF, ONE << 66, 64'h0123456789ABCDEF, 2'b10, 5'd0);
    vecs[3] = mkVec(64'h0123456789ABCDEF, (ONE << 9) | (ONE << 22), 64'h0123456789EBCFEF, 2'b11, 5'd4);
    vecs[3].exp_pos[0] = {3'd1, 3'd1};
    vecs[3].exp_pos[1] = {3'd1, 3'd6};
    vecs[3].exp_pos[2] = {3'd2, 3'd1};
    vecs[3].exp_pos[3] = {3'd2, 3'd6};
    vecs[4] = mkVec(64'h0123456789ABCDEF, ONE << 75, 64'h0123456789ABCDEF, 2'b10, 5'd0);
    vecs[5] = mkVec(64'h0123456789ABCDEF, (ONE << 32) | (ONE << 39), 64'h012345E689ABCDEF, 2'b11, 5'd0);
    vecs[6] = mkVec(64'h0123456789ABCDEF, (ONE << 0) | (ONE << 9) | (ONE << 18) | (ONE << 27) | (ONE << 36),
                    64'h0123457781AFCFEE, 2'b11, 5'd16);
    for (int k = 0; k < 16; k++) vecs[6].exp_pos[k] = {3'(k / 5), 3'(k % 5)};
    vecs[7] = mkVec(64'hFFFFFFFFFFFFFFFF, ONE << 63, 64'hFFFFFFFFFFFFFFFF, 2'b01, 5'd1);
    vecs[7].exp_pos[0] = {3'd7, 3'd7};
    vecs[8] = mkVec(64'h0, ONE << 0, 64'h0, 2'b01, 5'd1);
    vecs[8].exp_pos[0] = {3'd0, 3'd0};
    vecs[9] = mkVec(64'h0123456789ABCDEF, (ONE << 71) | (ONE << 72), 64'h0023456789ABCDEF, 2'b01, 5'd1);
    vecs[9].exp_pos[0] = {3'd7, 3'd0};

    tick();
    tick();
    checkValue("reset in_ready", in_ready, 0);
    checkValue("reset out_valid", out_valid, 0);
    checkValue("reset pos_valid", pos_valid, 0);
    checkValue("reset out_data", out_data, 0);
    checkValue("reset out_status", out_status, 0);
    checkValue("reset out_err_count", out_err_count, 0);
    rst = 1'b1;
    #1;
    checkValue("release in_ready", in_ready, 1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], w);
      checkOutput(vecs[i], i);
    end

    // Backpressure: out_ready low for 5 cycles, pos_ready alternating.
    applyStimulus(vecs[3], w);
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    checkValue("bp latency", lat, 2);
    n = 0; out_done = 0; stall = 0; stall_pos = '0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (n == 4 && out_done) break;
      if (stall) checkValue("bp stall hold", {pos_valid, pos_row, pos_col}, {1'b1, stall_pos});
      checkValue("bp in_ready", in_ready, 0);
      if (!out_done) begin
        checkValue("bp out_valid", out_valid, 1);
        checkValue("bp out_data", out_data, vecs[3].exp_data);
        checkValue("bp out_status", out_status, vecs[3].exp_status);
      end else begin
        checkValue("bp out_valid dropped", out_valid, 0);
      end
      out_ready = (cyc >= 5);
      pos_ready = ((cyc % 2) == 1);
      out_hs    = out_valid && out_ready;
      stall     = pos_valid && !pos_ready;
      stall_pos = {pos_row, pos_col};
      if (pos_valid && pos_ready) begin
        if (n < 4) begin
          checkValue($sformatf("bp pos%0d", n), {pos_row, pos_col}, vecs[3].exp_pos[n]);
          checkValue($sformatf("bp pos%0d last", n), pos_last, (n == 3));
        end
        n++;
      end
      tick();
      if (out_hs) out_done = 1;
    end
    checkValue("bp positions", n, 4);
    checkValue("bp out handshake", out_done, 1);
    checkValue("bp in_ready after", in_ready, 1);
    checkValue("bp pos_valid after", pos_valid, 0);
    out_ready = 1'b0;
    pos_ready = 1'b1;
    applyStimulus(vecs[0], w);
    checkValue("bp next accept wait", w, 0);
    checkOutput(vecs[0], 100);

    // Reset while reporting a corrected frame.
    applyStimulus(vecs[1], w);
    tick();
    tick();
    checkValue("rst pre out_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    checkValue("rst out_valid", out_valid, 0);
    checkValue("rst pos_valid", pos_valid, 0);
    checkValue("rst in_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    checkValue("rst release in_ready", in_ready, 1);
    applyStimulus(vecs[0], w);
    checkOutput(vecs[0], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_code_link.md
Name: product_code_link

Overview:
- Parametrised successor of the fixed 64-bit format/encode/decode chain.
- Accepts a ROWS x COLS data word and builds a 2-D even-parity product codeword. The codeword passes through an error-injection channel mask, is decoded, single errors are corrected, and the frame is classified.
- Streams every candidate error (row, col) position over a separate valid/ready port.
- Sits between the data source and downstream consumer, replacing the hard-wired 16-entry error-position outputs.

Parameters:
ROWS, 8, matrix rows
COLS, 8, matrix columns
MAX_POS, 16, maximum positions reported per frame (>=1)
DATA_W, ROWS*COLS, derived data width
CW_W, DATA_W+ROWS+COLS, derived codeword width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
in_valid  in  1  source word valid
in_ready  out  1  block accepts word
in_data  in  DATA_W  data; bit r*COLS+c = cell (r,c)
chan_err_mask  in  CW_W  XORed onto codeword at accept
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  corrected (or received) data
out_status  out  2  00 clean, 01 corrected, 10 parity-only, 11 uncorrectable
out_err_count  out  $clog2(MAX_POS+1)  positions that will be streamed
pos_valid  out  1  position valid
pos_ready  in  1  position consumer ready
pos_row  out  $clog2(ROWS)  row index
pos_col  out  $clog2(COLS)  column index
pos_last  out  1  final position of frame

Behaviour:
- Codeword layout:
  - [DATA_W-1:0] data.
  - [DATA_W+r] even parity of row r.
  - [DATA_W+ROWS+c] even parity of column c.
- Reset (rst low, async): state IDLE; all registered outputs 0; in_ready forced 0 while rst low. Mid-frame reset discards the frame with no partial output.
- FSM IDLE -> DECODE -> REPORT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (edge T), register codeword XOR chan_err_mask, then go to DECODE.
- DECODE (one cycle):
  - Recompute parities; row_syn/col_syn = mismatch vectors; R/C = popcounts.
  - Classify:
    - R=0,C=0 -> clean.
    - R=1,C=1 -> corrected; flip bit (r,c) of data.
    - exactly one of R,C =1, other 0 -> parity-only; data unchanged.
    - otherwise -> uncorrectable; data = received.
  - out_err_count:
    - clean/parity-only -> 0.
    - otherwise -> min(R*C, MAX_POS).
  - Register results; go to REPORT.
- REPORT:
  - out_valid=1 from edge T+2 until out handshake.
  - Position walker scans cells row-major, one cell per cycle, starting at (0,0).
    - Cell with both row_syn and col_syn set: pos_valid=1; advance on pos_ready.
    - Otherwise skip without stall.
  - pos_last=1 when emitted+1 == out_err_count.
  - Walker stops at MAX_POS emitted or end of matrix. Count 0 -> no pos_valid.
  - Return to IDLE the cycle after both the out handshake and the final pos handshake (or walker done) have completed, in either order.
  - in_ready stays 0 throughout DECODE/REPORT; in_valid is ignored.
- Outputs hold stable while valid and not ready.
- Best-case latency: accept to out_valid = 2 cycles.
- Back-to-back throughput: one frame per 3 + position cycles.

Decomposition:
- Package codec_pkg:
  - status encodings (ST_CLEAN, ST_CORR, ST_PAR, ST_UNCORR);
  - width helper functions for CW_W, row/col/count widths.
- Sub-module parity_syndrome: combinational ROWS x COLS row/column parity generator, instanced once for encode and once for decode check.

Test Plan:
- 8x8, in_data=64'h0123456789ABCDEF, mask=0 -> out_valid 2 cycles after accept, out_data unchanged, status 00, count 0, no pos_valid.
- mask bit 29 (cell 3,5) -> out_data=64'h0123456789ABCDEF, status 01, count 1, one position (3,5) with pos_last=1.
- mask bit 66 (row-2 parity) -> data unchanged, status 10, count 0.
- mask bits 9 and 22 (cells 1,1 and 2,6):
  - status 11, count 4, received data output;
  - positions in order (1,1), (1,6), (2,1), (2,6); pos_last on the 4th.
- Backpressure:
  - out_ready=0 for 5 cycles, pos_ready alternating -> outputs stable, in_ready=0;
  - next frame accepted one cycle after last handshake.
- rst low during REPORT -> out_valid/pos_valid drop to 0 immediately; after release in_ready=1 and a clean frame decodes correctly.
